// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields and operands, resolves forwarding, stalls on load-use.
// Latency: 1 cycle from ID inputs to ex_* outputs; stall_id is combinational in the same cycle.
// Backpressure: stall_id asks IF/ID and PC to hold one cycle on load-use; flush overrides it.
//
// Ports:
//   clk, rst_n                 - core clock (rising edge), async active-low reset
//   id_*                       - decoded instruction from ID (control, indices, RF data, immediate)
//   ex_fwd_wD                  - ALU result of the instruction currently held in this register
//   mem_we/mem_wR/mem_wD       - MEM-stage writeback candidate
//   wb_we/wb_wR/wb_wD          - WB-stage writeback candidate
//   flush                      - taken branch/jump resolved in EX; ID instruction is killed
//   stall_id                   - hold IF/ID and PC this cycle
//   ex_*                       - registered fields driving EX
//   stall_cnt, flush_cnt       - hazard statistics, live only when HAZARD_CNT_EN is defined
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_wR,
  input  logic [XLEN-1:0] id_rD1,
  input  logic [XLEN-1:0] id_rD2,
  input  logic [XLEN-1:0] id_ext,
  input  logic [1:0]      id_pc_sel,
  input  logic [1:0]      id_reg_write,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_op_B_sel,
  input  logic            id_reg_we,
  input  logic            id_rD1_re,
  input  logic            id_rD2_re,
  input  logic [XLEN-1:0] ex_fwd_wD,
  input  logic            mem_we,
  input  logic [4:0]      mem_wR,
  input  logic [XLEN-1:0] mem_wD,
  input  logic            wb_we,
  input  logic [4:0]      wb_wR,
  input  logic [XLEN-1:0] wb_wD,
  input  logic            flush,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rD1,
  output logic [XLEN-1:0] ex_rD2,
  output logic [XLEN-1:0] ex_ext,
  output logic [4:0]      ex_wR,
  output logic [1:0]      ex_pc_sel,
  output logic [1:0]      ex_reg_write,
  output logic [3:0]      ex_alu_ctrl,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_op_B_sel,
  output logic            ex_reg_we,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext;
    logic [4:0]      wr;
    logic [1:0]      pc_sel;
    logic [1:0]      reg_write;
    logic [3:0]      alu_ctrl;
    logic            mem_write;
    logic            branch;
    logic            op_b_sel;
    logic            reg_we;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic ld_use;
  logic ex_alu_src;

  // reg_write==2'b10 marks a load: its data is not ready until MEM.
  always_comb begin
    ld_use = ex_q.valid && ex_q.reg_we && (ex_q.reg_write == 2'b10) && (ex_q.wr != 5'd0) &&
             id_valid && ((id_rD1_re && (id_rs1 == ex_q.wr)) ||
                          (id_rD2_re && (id_rs2 == ex_q.wr)));
  end

  assign stall_id = ld_use && !flush;

  // Only plain ALU results are forwarded out of EX; link values arrive via MEM/WB.
  assign ex_alu_src = ex_q.valid && ex_q.reg_we && (ex_q.reg_write == 2'b00);

  function automatic logic [XLEN-1:0] fwd_sel(input logic            re,
                                              input logic [4:0]      rs,
                                              input logic [XLEN-1:0] rf_val,
                                              input logic            ex_src,
                                              input logic [4:0]      ex_wr,
                                              input logic [XLEN-1:0] ex_wd,
                                              input logic            m_we,
                                              input logic [4:0]      m_wr,
                                              input logic [XLEN-1:0] m_wd,
                                              input logic            w_we,
                                              input logic [4:0]      w_wr,
                                              input logic [XLEN-1:0] w_wd);
    fwd_sel = rf_val;
    // x0 is hardwired: the RF already returns 0, so never override it.
    if (re && (rs != 5'd0)) begin
      if (ex_src && (ex_wr == rs)) begin
        fwd_sel = ex_wd;
      end else if (m_we && (m_wr == rs)) begin
        fwd_sel = m_wd;
      end else if (w_we && (w_wr == rs)) begin
        fwd_sel = w_wd;
      end
    end
  endfunction

  always_comb begin
    // Default is the bubble: everything cleared.
    ex_d = '0;
    if (!flush && !ld_use) begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.rd1       = fwd_sel(id_rD1_re, id_rs1, id_rD1, ex_alu_src, ex_q.wr, ex_fwd_wD,
                               mem_we, mem_wR, mem_wD, wb_we, wb_wR, wb_wD);
      ex_d.rd2       = fwd_sel(id_rD2_re, id_rs2, id_rD2, ex_alu_src, ex_q.wr, ex_fwd_wD,
                               mem_we, mem_wR, mem_wD, wb_we, wb_wR, wb_wD);
      ex_d.ext       = id_ext;
      ex_d.wr        = id_wR;
      ex_d.pc_sel    = id_pc_sel;
      ex_d.reg_write = id_reg_write;
      ex_d.alu_ctrl  = id_alu_ctrl;
      ex_d.mem_write = id_mem_write;
      ex_d.branch    = id_branch;
      ex_d.op_b_sel  = id_op_B_sel;
      ex_d.reg_we    = id_reg_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rD1       = ex_q.rd1;
  assign ex_rD2       = ex_q.rd2;
  assign ex_ext       = ex_q.ext;
  assign ex_wR        = ex_q.wr;
  assign ex_pc_sel    = ex_q.pc_sel;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_alu_ctrl  = ex_q.alu_ctrl;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_branch    = ex_q.branch;
  assign ex_op_B_sel  = ex_q.op_b_sel;
  assign ex_reg_we    = ex_q.reg_we;

`ifdef HAZARD_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running 32-bit counters; natural wrap at 0xFFFFFFFF.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_id};
    flush_cnt_d = flush_cnt_q + {31'd0, flush && id_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
